// File: rtl/interrupt_pkg.sv
// Shared types and constants for the interrupt entry sequencer.
package interrupt_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned FL_W   = 3;
  localparam int unsigned WORD_W = 16;

  localparam logic [WORD_W-1:0] DEFAULT_VECTOR_ADDR = 16'h0002;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_PUSH_HI,
    ST_PUSH_LO,
    ST_PUSH_FL,
    ST_VECTOR,
    ST_LOAD,
    ST_SERVICE
  } state_e;

  // Order in which context words are pushed to the stack
  typedef enum logic [1:0] {
    CTX_HI = 2'd0,
    CTX_LO = 2'd1,
    CTX_FL = 2'd2
  } ctx_word_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [FL_W-1:0] fl;
  } ctx_t;

  function automatic logic [WORD_W-1:0] ctx_word(input ctx_t ctx, input ctx_word_e sel);
    logic [WORD_W-1:0] w;
    w = '0;
    case (sel)
      CTX_HI:  w = ctx.pc[PC_W-1:WORD_W];
      CTX_LO:  w = ctx.pc[WORD_W-1:0];
      CTX_FL:  w = {{(WORD_W-FL_W){1'b0}}, ctx.fl};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Synchronises the async interrupt level, detects rising edges and keeps a
// single-deep pending flag plus a sticky overflow flag.
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_irq,
  input  logic i_clear,
  output logic o_pending,
  output logic o_dropped
);

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;
  logic r_pending;
  logic r_dropped;
  logic w_edge;

  assign w_edge    = r_sync2 & ~r_sync3;
  assign o_pending = r_pending;
  assign o_dropped = r_dropped;

  // A new edge wins over a same-cycle clear so it is never lost
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_sync3   <= 1'b0;
      r_pending <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_sync1 <= i_irq;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      if (w_edge) begin
        r_pending <= 1'b1;
        if (r_pending && !i_clear) begin
          r_dropped <= 1'b1;
        end
      end else if (i_clear) begin
        r_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: freezes fetch, drains, pushes PC/flags context,
// fetches the handler vector and redirects fetch, then waits for RTI.
module interrupt_sequencer
  import interrupt_pkg::*;
#(
  parameter int unsigned       DRAIN_CYCLES = 3,
  parameter logic [WORD_W-1:0] VECTOR_ADDR  = DEFAULT_VECTOR_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              irq_in,
  input  logic              stall_in,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [FL_W-1:0]   flags_in,
  input  logic              rti_commit,
  output logic              int_out,
  output logic              freeze_fetch,
  output logic              push_valid,
  output logic [WORD_W-1:0] push_data,
  input  logic              push_ready,
  output logic              rd_req,
  output logic [WORD_W-1:0] rd_addr,
  input  logic              rd_valid,
  input  logic [WORD_W-1:0] rd_data,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_load_value,
  output logic              busy,
  output logic              irq_dropped
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  ctx_t              r_ctx;
  logic [WORD_W-1:0] r_vector;
  logic              r_rd_armed;
  logic              r_int_out;
  logic              r_freeze;
  logic              r_push_valid;
  logic [WORD_W-1:0] r_push_data;
  logic              r_rd_req;
  logic              r_pc_load;
  logic              r_busy;

  state_e            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_take;
  logic              w_latch;
  logic              w_armed_nxt;
  logic              w_pending;
  logic              w_dropped;
  logic              w_freeze_nxt;
  logic              w_push_valid_nxt;
  logic [WORD_W-1:0] w_push_data_nxt;
  logic              w_rd_req_nxt;
  logic              w_pc_load_nxt;
  logic              w_busy_nxt;

  irq_sync_edge u_sync (
    .clk      (clk),
    .reset    (reset),
    .i_irq    (irq_in),
    .i_clear  (w_take),
    .o_pending(w_pending),
    .o_dropped(w_dropped)
  );

  // Next state plus next-cycle outputs; outputs are registered from next state
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_take      = 1'b0;
    w_latch     = 1'b0;
    w_armed_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pending && !stall_in && !branch_taken) begin
          w_take      = 1'b1;
          w_cnt_nxt   = CNT_W'(DRAIN_CYCLES - 1);
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_PUSH_HI;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_PUSH_HI: if (push_ready) w_state_nxt = ST_PUSH_LO;
      ST_PUSH_LO: if (push_ready) w_state_nxt = ST_PUSH_FL;
      ST_PUSH_FL: if (push_ready) w_state_nxt = ST_VECTOR;
      ST_VECTOR: begin
        // Read data cannot return before the request has been seen for a cycle
        if (r_rd_armed && rd_valid) begin
          w_latch     = 1'b1;
          w_state_nxt = ST_LOAD;
        end else begin
          w_armed_nxt = 1'b1;
        end
      end
      ST_LOAD:    w_state_nxt = ST_SERVICE;
      ST_SERVICE: if (rti_commit) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase

    w_freeze_nxt     = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_SERVICE);
    w_push_valid_nxt = (w_state_nxt == ST_PUSH_HI) || (w_state_nxt == ST_PUSH_LO) ||
                       (w_state_nxt == ST_PUSH_FL);
    w_rd_req_nxt     = (w_state_nxt == ST_VECTOR);
    w_pc_load_nxt    = (w_state_nxt == ST_LOAD);
    w_busy_nxt       = (w_state_nxt != ST_IDLE);
    case (w_state_nxt)
      ST_PUSH_HI: w_push_data_nxt = ctx_word(r_ctx, CTX_HI);
      ST_PUSH_LO: w_push_data_nxt = ctx_word(r_ctx, CTX_LO);
      ST_PUSH_FL: w_push_data_nxt = ctx_word(r_ctx, CTX_FL);
      default:    w_push_data_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_ctx        <= '0;
      r_vector     <= '0;
      r_rd_armed   <= 1'b0;
      r_int_out    <= 1'b0;
      r_freeze     <= 1'b0;
      r_push_valid <= 1'b0;
      r_push_data  <= '0;
      r_rd_req     <= 1'b0;
      r_pc_load    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rd_armed   <= w_armed_nxt;
      r_int_out    <= w_take;
      r_freeze     <= w_freeze_nxt;
      r_push_valid <= w_push_valid_nxt;
      r_push_data  <= w_push_data_nxt;
      r_rd_req     <= w_rd_req_nxt;
      r_pc_load    <= w_pc_load_nxt;
      r_busy       <= w_busy_nxt;
      if (w_take) begin
        r_ctx.pc <= pc_in;
        r_ctx.fl <= flags_in;
      end
      if (w_latch) begin
        r_vector <= rd_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (DRAIN_CYCLES != 0) else $error("interrupt_sequencer: DRAIN_CYCLES must be nonzero");
    end
  end

  assign int_out       = r_int_out;
  assign freeze_fetch  = r_freeze;
  assign push_valid    = r_push_valid;
  assign push_data     = r_push_data;
  assign rd_req        = r_rd_req;
  assign rd_addr       = VECTOR_ADDR;
  assign pc_load       = r_pc_load;
  assign pc_load_value = {16'h0000, r_vector};
  assign busy          = r_busy;
  assign irq_dropped   = w_dropped;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed self-checking bench for interrupt_sequencer (DRAIN_CYCLES=3).
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq_in;
  logic        stall_in;
  logic        branch_taken;
  logic [31:0] pc_in;
  logic [2:0]  flags_in;
  logic        rti_commit;
  logic        int_out;
  logic        freeze_fetch;
  logic        push_valid;
  logic [15:0] push_data;
  logic        push_ready;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        pc_load;
  logic [31:0] pc_load_value;
  logic        busy;
  logic        irq_dropped;

  int unsigned n_vec  = 0;
  int unsigned n_err  = 0;
  int unsigned n_push = 0;

  interrupt_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .irq_in       (irq_in),
    .stall_in     (stall_in),
    .branch_taken (branch_taken),
    .pc_in        (pc_in),
    .flags_in     (flags_in),
    .rti_commit   (rti_commit),
    .int_out      (int_out),
    .freeze_fetch (freeze_fetch),
    .push_valid   (push_valid),
    .push_data    (push_data),
    .push_ready   (push_ready),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .pc_load      (pc_load),
    .pc_load_value(pc_load_value),
    .busy         (busy),
    .irq_dropped  (irq_dropped)
  );

  always #5 clk = ~clk;

  // Count words the stack actually accepted
  always @(posedge clk) begin
    if (!reset && push_valid && push_ready) n_push <= n_push + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Control bits: {int_out, freeze_fetch, push_valid, rd_req, pc_load, busy}
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, 32'({int_out, freeze_fetch, push_valid, rd_req, pc_load, busy}), 32'(exp));
  endtask

  // Leaves the synchronised edge active in the current cycle; next step sets pending
  task automatic irq_edge();
    irq_in = 1'b0;
    step();
    step();
    irq_in = 1'b1;
    step();
    step();
  endtask

  // Current cycle must be IDLE with pending set; runs a full unstalled entry
  task automatic run_seq(input string tag, input logic [31:0] pc, input logic [2:0] fl,
                         input logic [15:0] vec, input bit rti_in_drain);
    pc_in = pc; flags_in = fl; rd_data = vec; push_ready = 1'b1; rd_valid = 1'b1;
    step(); chk_ctl({tag, ".entry"}, 6'b110001);
    pc_in = ~pc; flags_in = ~fl; rti_commit = rti_in_drain;
    step(); rti_commit = 1'b0; chk_ctl({tag, ".drain1"}, 6'b010001);
    step(); chk_ctl({tag, ".drain2"}, 6'b010001);
    step(); chk_ctl({tag, ".push_hi"}, 6'b011001); chk({tag, ".hi_data"}, 32'(push_data), 32'(pc[31:16]));
    step(); chk_ctl({tag, ".push_lo"}, 6'b011001); chk({tag, ".lo_data"}, 32'(push_data), 32'(pc[15:0]));
    step(); chk_ctl({tag, ".push_fl"}, 6'b011001); chk({tag, ".fl_data"}, 32'(push_data), {29'd0, fl});
    step(); chk_ctl({tag, ".vector1"}, 6'b010101);
    step(); chk_ctl({tag, ".vector2"}, 6'b010101);
    step(); chk_ctl({tag, ".load"}, 6'b010011); chk({tag, ".load_val"}, pc_load_value, {16'h0000, vec});
    step(); chk_ctl({tag, ".service"}, 6'b000001);
  endtask

  int unsigned base;

  initial begin
    reset = 1'b1; irq_in = 1'b0; stall_in = 1'b0; branch_taken = 1'b0;
    pc_in = '0; flags_in = '0; rti_commit = 1'b0; push_ready = 1'b1;
    rd_valid = 1'b1; rd_data = '0;
    step(); step();
    chk_ctl("rst.ctl", 6'b000000);
    chk("rst.push_data", 32'(push_data), 32'h0);
    chk("rst.pc_load_value", pc_load_value, 32'h0);
    chk("rst.rd_addr", 32'(rd_addr), 32'h0002);
    chk("rst.dropped", 32'(irq_dropped), 32'h0);
    reset = 1'b0;

    // Basic entry; rti pulses in IDLE and DRAIN must be ignored
    rti_commit = 1'b1;
    step(); rti_commit = 1'b0; chk_ctl("t1.rti_idle", 6'b000000);
    irq_edge();
    chk_ctl("t1.sync_latency", 6'b000000);
    step(); chk_ctl("t1.pending_idle", 6'b000000);
    run_seq("t1", 32'h0000_0040, 3'b101, 16'h0100, 1'b1);

    // Two edges while in service overflow the single-deep pending flag
    irq_edge();
    step(); chk_ctl("t4.svc1", 6'b000001); chk("t4.drop_early", 32'(irq_dropped), 32'h0);
    irq_edge();
    chk("t4.drop_pre", 32'(irq_dropped), 32'h0);
    step(); chk("t4.dropped", 32'(irq_dropped), 32'h1); chk_ctl("t4.svc2", 6'b000001);
    rti_commit = 1'b1;
    step(); rti_commit = 1'b0; chk_ctl("t4.idle", 6'b000000);
    pc_in = 32'h0001_0040; flags_in = 3'b010; rd_data = 16'h0200;
    step(); chk_ctl("t4.entry", 6'b110001);
    pc_in = 32'hFFFF_FFFF; flags_in = 3'b111;
    step(); step(); chk_ctl("t3.drain", 6'b010001);
    base = n_push;
    step(); chk_ctl("t3.push_hi", 6'b011001); chk("t3.hi_data", 32'(push_data), 32'h0001);
    step(); chk("t3.lo_data", 32'(push_data), 32'h0040);
    for (int i = 0; i < 4; i++) begin
      push_ready = 1'b0;
      step();
      chk_ctl("t3.lo_hold_ctl", 6'b011001);
      chk("t3.lo_hold_data", 32'(push_data), 32'h0040);
    end
    push_ready = 1'b1;
    step(); chk_ctl("t3.push_fl", 6'b011001); chk("t3.fl_data", 32'(push_data), 32'h0002);
    step(); chk_ctl("t3.vector1", 6'b010101);
    step(); chk_ctl("t3.vector2", 6'b010101);
    step(); chk_ctl("t3.load", 6'b010011); chk("t3.load_val", pc_load_value, 32'h0000_0200);
    step(); chk_ctl("t3.service", 6'b000001);
    chk("t3.push_count", n_push - base, 32'd3);
    chk("t3.dropped_sticky", 32'(irq_dropped), 32'h1);

    // Entry deferred by branch_taken (2 cycles) then stall_in (1 cycle)
    rti_commit = 1'b1;
    step(); rti_commit = 1'b0; chk_ctl("t2.idle", 6'b000000);
    irq_edge();
    step();
    branch_taken = 1'b1; pc_in = 32'hDEAD_BEEF;
    step(); chk_ctl("t2.defer1", 6'b000000);
    step(); chk_ctl("t2.defer2", 6'b000000);
    branch_taken = 1'b0; stall_in = 1'b1;
    step(); chk_ctl("t2.stall", 6'b000000);
    stall_in = 1'b0;
    run_seq("t2", 32'hCAFE_0010, 3'b011, 16'h0300, 1'b0);

    // Reset while pushing, then a clean sequence
    rti_commit = 1'b1;
    step(); rti_commit = 1'b0;
    irq_edge();
    step();
    pc_in = 32'h1111_2222; flags_in = 3'b001;
    step(); chk_ctl("t5.entry", 6'b110001);
    step(); step();
    step(); chk_ctl("t5.push_hi", 6'b011001); chk("t5.hi_data", 32'(push_data), 32'h1111);
    reset = 1'b1;
    step();
    chk_ctl("t5.rst_ctl", 6'b000000);
    chk("t5.rst_push_data", 32'(push_data), 32'h0);
    chk("t5.rst_pc_load_value", pc_load_value, 32'h0);
    chk("t5.rst_dropped", 32'(irq_dropped), 32'h0);
    chk("t5.rst_rd_addr", 32'(rd_addr), 32'h0002);
    reset = 1'b0;
    irq_edge();
    step();
    run_seq("t5", 32'h0000_0040, 3'b101, 16'h0100, 1'b0);
    chk("t5.dropped_clear", 32'(irq_dropped), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Sits directly upstream of the pipeline's `interrupt` input and the stack port. It synchronises and edge-detects the external interrupt request and captures the return context: 32-bit next PC plus 3-bit flags. It freezes fetch, drains the pipeline, then pushes the 48-bit context to the stack as three 16-bit words, reads the handler vector from data memory, and redirects fetch. After that it stays in service until RTI commits.

## Interface
Parameters:
- `DRAIN_CYCLES`, default 3: cycles to wait after entry so in-flight instructions reach memory/writeback.
- `VECTOR_ADDR`, default 16'h0002: data-memory address holding the handler start address.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `irq_in`  in  1  external interrupt request; asynchronous level.
- `stall_in`  in  1  stall from the hazard unit.
- `branch_taken`  in  1  a branch or jump redirects fetch this cycle.
- `pc_in`  in  32  PC fetch will use next.
- `flags_in`  in  3  current condition-code register.
- `rti_commit`  in  1  one-cycle pulse when an RTI leaves writeback.
- `int_out`  out  1  one-cycle pulse into the pipeline's interrupt input.
- `freeze_fetch`  out  1  holds the fetch PC.
- `push_valid`  out  1  stack-push request.
- `push_data`  out  16  word being pushed.
- `push_ready`  in  1  stack accepted `push_data` this cycle.
- `rd_req`  out  1  memory read request.
- `rd_addr`  out  16  always `VECTOR_ADDR`.
- `rd_valid`  in  1  `rd_data` is valid.
- `rd_data`  in  16  memory read data.
- `pc_load`  out  1  one-cycle fetch redirect.
- `pc_load_value`  out  32  `{16'h0000, vector}`.
- `busy`  out  1  high in every state except IDLE.
- `irq_dropped`  out  1  sticky overflow flag; cleared only by reset.

## Operation
- `irq_in` passes through a 2-flop synchroniser. A rising edge of the synchronised signal sets `pending` (single-deep).
- A further edge while `pending` is already set sets `irq_dropped`.
- States: IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_FL, VECTOR, LOAD, SERVICE.
- IDLE → DRAIN when `pending & !stall_in & !branch_taken`. On this transition:
  - capture `ctx_pc = pc_in` and `ctx_fl = flags_in`;
  - clear `pending`;
  - pulse `int_out`;
  - load the counter with `DRAIN_CYCLES-1`.
- If `stall_in` or `branch_taken` is high, entry is deferred and retried every cycle. The captured PC is therefore never a squashed or stalled one.
- DRAIN: decrement the counter; go to PUSH_HI in the cycle after the counter reads 0.
- Push states hold `push_valid=1` and advance only on `push_ready`:
  - PUSH_HI: `push_data = ctx_pc[31:16]`;
  - PUSH_LO: `push_data = ctx_pc[15:0]`;
  - PUSH_FL: `push_data = {13'b0, ctx_fl}`.
- VECTOR: hold `rd_req=1` until `rd_valid`; latch `rd_data` into `vector`; go to LOAD.
- LOAD: `pc_load=1` for exactly one cycle; go to SERVICE.
- `freeze_fetch` is high from the DRAIN entry cycle through LOAD inclusive.
- SERVICE: `busy=1`, fetch free; go to IDLE on `rti_commit`.
  - An edge arriving during service sets `pending`; it is taken from IDLE one cycle after return.
- `rti_commit` in any state other than SERVICE is ignored.

## Timing
- Reset: state IDLE, `pending=0`, counter 0, synchroniser flops 0, `irq_dropped=0`. All outputs 0 except `rd_addr`, which is always `VECTOR_ADDR`.
- `irq_in` rising edge → `pending=1` 3 cycles later: 2 synchroniser flops plus the edge register.
- Entry → first `push_valid`: `DRAIN_CYCLES+1` cycles.
- Minimum entry → `pc_load`, with `push_ready` and `rd_valid` always high: `DRAIN_CYCLES + 6` cycles.
- `push_data` and `rd_req` are stable while waiting for their handshake.
- Simultaneous `push_ready` and state exit: the word is consumed exactly once.
- Reset mid-sequence, including while `push_valid` is high: return to IDLE next cycle and drop the context. Partial stack pushes are the stack block's concern.
- `DRAIN_CYCLES=0` is illegal; it is checked by an assertion.

## Structure
- Shared package `interrupt_pkg`:
  - state enum;
  - context-word ordering constants (HI, LO, FL);
  - default `VECTOR_ADDR`.
- One sub-module `irq_sync_edge`: 2-flop synchroniser, edge detector, `pending`/`irq_dropped` logic.
- The FSM, drain counter and context registers live in the top level.

## Test plan
- Edge on `irq_in` with `pc_in=32'h0000_0040`, `flags_in=3'b101`, `DRAIN_CYCLES=3`, `push_ready=1`, and `rd_valid=1` with `rd_data=16'h0100` → after the 3-cycle synchroniser/edge latency:
  - `int_out` pulses once;
  - pushes are `16'h0000`, `16'h0040`, `16'h0005` in order;
  - `pc_load=1` with `pc_load_value=32'h0000_0100` 9 cycles after entry.
- `pending` high with `branch_taken=1` for 2 cycles, then 0 → entry is deferred 2 cycles; the captured PC is the `pc_in` of the entry cycle.
- `push_ready` low for 4 cycles during PUSH_LO → `push_data` holds `16'h0040` throughout; exactly three pushes in total.
- Two edges during SERVICE → `irq_dropped=1`; after `rti_commit` the second interrupt enters 1 cycle later.
- `reset` asserted in PUSH_HI → next cycle state is IDLE and all outputs 0; a new edge runs a clean full sequence.
- `rti_commit` pulsed in IDLE and DRAIN → no state change and no output change.
